// File: rtl/ahb_gpio_param.sv
`default_nettype none
// ahb_gpio_param: AHB-Lite GPIO slave with per-bit direction, rising-edge interrupts and pad parity.
// Revision 1.0

module ahb_gpio_param #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic             HWRITE,
  input  logic             HREADY,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [31:0]      HWDATA,
  input  logic [WIDTH:0]   GPIOIN,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  output logic [WIDTH:0]   GPIOOUT,
  output logic [WIDTH-1:0] GPIODIR,
  output logic             GPIOIRQ,
  output logic             PARITYERR
);

  localparam logic [7:0] A_DATA    = 8'h00;
  localparam logic [7:0] A_DIR     = 8'h04;
  localparam logic [7:0] A_INTMASK = 8'h08;
  localparam logic [7:0] A_INTSTAT = 8'h0C;
  localparam logic [7:0] A_CTRL    = 8'h10;
  localparam logic [7:0] A_PARSTAT = 8'h14;

  logic [7:0]       addr_q;
  logic             write_q, sel_q, trans_q;
  logic [WIDTH-1:0] out_q, dir_q, mask_q, stat_q, prev_q;
  logic [WIDTH-1:0] out_d, dir_d, mask_d, stat_d;
  logic             odd_q, odd_d, par_q, par_d;
  logic [WIDTH:0]   sync_q [SYNC_STAGES];

  logic             wr_en;
  logic [WIDTH-1:0] wdat, edge_set;
  logic [WIDTH:0]   sync_w;
  logic             par_set;

  assign wr_en    = sel_q & write_q & trans_q;
  assign wdat     = HWDATA[WIDTH-1:0];
  assign sync_w   = sync_q[SYNC_STAGES-1];
  // prev tracks sync regardless of DIR, so flipping a bit to input never fakes an edge
  assign edge_set = sync_w[WIDTH-1:0] & ~prev_q & ~dir_q;
  assign par_set  = (^sync_w) ^ odd_q;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    stat_d = stat_q;
    odd_d  = odd_q;
    par_d  = par_q;
    if (wr_en) begin
      case (addr_q)
        A_DATA:    out_d  = (out_q & ~dir_q) | (wdat & dir_q);
        A_DIR:     dir_d  = wdat;
        A_INTMASK: mask_d = wdat;
        A_INTSTAT: stat_d = stat_q & ~wdat;
        A_CTRL:    odd_d  = HWDATA[0];
        A_PARSTAT: par_d  = par_q & ~HWDATA[0];
        default:   ;
      endcase
    end
    stat_d = stat_d | edge_set;
    par_d  = par_d | par_set;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      sel_q   <= 1'b0;
      trans_q <= 1'b0;
      out_q   <= '0;
      dir_q   <= '0;
      mask_q  <= '0;
      stat_q  <= '0;
      odd_q   <= 1'b0;
      par_q   <= 1'b0;
      prev_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      if (HREADY) begin
        addr_q  <= HADDR[7:0];
        write_q <= HWRITE;
        sel_q   <= HSEL;
        trans_q <= HTRANS[1];
      end
      out_q     <= out_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      stat_q    <= stat_d;
      odd_q     <= odd_d;
      par_q     <= par_d;
      prev_q    <= sync_w[WIDTH-1:0];
      sync_q[0] <= GPIOIN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    HRDATA = '0;
    case (addr_q)
      A_DATA:    HRDATA[WIDTH-1:0] = (out_q & dir_q) | (sync_w[WIDTH-1:0] & ~dir_q);
      A_DIR:     HRDATA[WIDTH-1:0] = dir_q;
      A_INTMASK: HRDATA[WIDTH-1:0] = mask_q;
      A_INTSTAT: HRDATA[WIDTH-1:0] = stat_q;
      A_CTRL:    HRDATA[0]         = odd_q;
      A_PARSTAT: HRDATA[0]         = par_q;
      default:   ;
    endcase
  end

  assign HREADYOUT = 1'b1;
  assign GPIOOUT   = {(^out_q) ^ odd_q, out_q};
  assign GPIODIR   = dir_q;
  assign GPIOIRQ   = |(stat_q & mask_q);
  assign PARITYERR = par_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, HADDR[31:8], HTRANS[0], HWDATA[31:WIDTH]};

endmodule

`default_nettype wire

// File: tb/tb_ahb_gpio_param.sv
`default_nettype none
// tb_ahb_gpio_param: randomized bus/pad stimulus checked every cycle against a register-level model.
// Revision 1.0

module tb_ahb_gpio_param;

  localparam int W = 16;
  localparam int S = 2;

  logic          HCLK, HRESET, HSEL, HWRITE, HREADY;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [1:0]    HTRANS;
  logic [W:0]    GPIOIN, GPIOOUT;
  logic [W-1:0]  GPIODIR;
  logic          HREADYOUT, GPIOIRQ, PARITYERR;

  ahb_gpio_param #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWDATA(HWDATA), .GPIOIN(GPIOIN),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .GPIOOUT(GPIOOUT), .GPIODIR(GPIODIR),
    .GPIOIRQ(GPIOIRQ), .PARITYERR(PARITYERR)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: architectural registers plus a history of sampled pad values (newest first)
  logic [W-1:0] m_out, m_dir, m_mask, m_stat;
  logic         m_odd, m_par, m_pend;
  logic [7:0]   m_pend_addr, m_capaddr;
  logic [W:0]   hist[$];
  logic [W:0]   gin_cur;

  function automatic logic [31:0] exp_rdata();
    logic [W:0] snow;
    logic [31:0] r;
    snow = hist[S-1];
    r = '0;
    case (m_capaddr)
      8'h00: for (int b = 0; b < W; b++) r[b] = m_dir[b] ? m_out[b] : snow[b];
      8'h04: r[W-1:0] = m_dir;
      8'h08: r[W-1:0] = m_mask;
      8'h0C: r[W-1:0] = m_stat;
      8'h10: r[0] = m_odd;
      8'h14: r[0] = m_par;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic cyc(input logic sel, input logic wr, input logic [1:0] trans, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic rst, input logic [W:0] gin);
    logic [W:0]   s_pre, p_pre;
    logic [W-1:0] rise, clr_i, wd;
    logic         perr, clr_p;
    @(negedge HCLK);
    HSEL = sel; HWRITE = wr; HTRANS = trans; HADDR = {24'h0, addr};
    HWDATA = wdata; HRESET = rst; GPIOIN = gin; HREADY = 1'b1;
    @(posedge HCLK);
    if (rst) begin
      m_out = '0; m_dir = '0; m_mask = '0; m_stat = '0; m_odd = 1'b0; m_par = 1'b0;
      m_pend = 1'b0; m_pend_addr = '0; m_capaddr = '0;
      hist = {};
      repeat (S + 1) hist.push_back('0);
    end else begin
      s_pre = hist[S-1];
      p_pre = hist[S];
      rise  = s_pre[W-1:0] & ~p_pre[W-1:0] & ~m_dir;
      perr  = (^s_pre) ^ m_odd;
      clr_i = '0; clr_p = 1'b0; wd = wdata[W-1:0];
      if (m_pend) begin
        case (m_pend_addr)
          8'h00: for (int b = 0; b < W; b++) if (m_dir[b]) m_out[b] = wd[b];
          8'h04: m_dir  = wd;
          8'h08: m_mask = wd;
          8'h0C: clr_i  = wd;
          8'h10: m_odd  = wdata[0];
          8'h14: clr_p  = wdata[0];
          default: ;
        endcase
      end
      m_stat = (m_stat & ~clr_i) | rise;
      m_par  = (m_par & ~clr_p) | perr;
      hist.push_front(gin);
      void'(hist.pop_back());
      m_pend      = sel & wr & trans[1];
      m_pend_addr = addr;
      m_capaddr   = addr;
    end
    #1;
    chk("GPIOOUT",   32'(GPIOOUT),   32'({(^m_out) ^ m_odd, m_out}));
    chk("GPIODIR",   32'(GPIODIR),   32'(m_dir));
    chk("GPIOIRQ",   32'(GPIOIRQ),   32'(|(m_stat & m_mask)));
    chk("PARITYERR", 32'(PARITYERR), 32'(m_par));
    chk("HREADYOUT", 32'(HREADYOUT), 32'h1);
    chk("HRDATA",    HRDATA,         exp_rdata());
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
    cyc(1'b1, 1'b1, 2'b10, addr, 32'h0, 1'b0, gin_cur);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, data, 1'b0, gin_cur);
  endtask

  task automatic rd_reg(input logic [7:0] addr);
    cyc(1'b1, 1'b0, 2'b10, addr, 32'h0, 1'b0, gin_cur);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 2'b00, 8'h00, 32'h0, 1'b0, gin_cur);
  endtask

  logic [7:0]  addr_tab [8];
  logic [31:0] rnd;
  logic [1:0]  tr;

  initial begin
    HSEL = 0; HWRITE = 0; HREADY = 1; HADDR = '0; HTRANS = '0; HWDATA = '0;
    HRESET = 1; GPIOIN = '0; gin_cur = '0;
    addr_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h18};

    cyc(1'b0, 1'b0, 2'b00, 8'h00, 32'h0, 1'b1, gin_cur);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 32'h0, 1'b1, gin_cur);
    chk("rst_gpioout", 32'(GPIOOUT), 32'h0);
    chk("rst_gpiodir", 32'(GPIODIR), 32'h0);
    chk("rst_irq_perr", {30'h0, GPIOIRQ, PARITYERR}, 32'h0);

    wr_reg(8'h04, 32'h0000_00FF);
    wr_reg(8'h00, 32'h0000_1234);
    chk("dir_data_out", 32'(GPIOOUT), 32'h0001_0034);
    rd_reg(8'h00);
    chk("data_read", HRDATA, 32'h0000_0034);

    wr_reg(8'h10, 32'h0000_0001);
    chk("odd_parity_bit", 32'(GPIOOUT[W]), 32'h0);
    rd_reg(8'h10);
    chk("ctrl_read", HRDATA, 32'h0000_0001);
    wr_reg(8'h10, 32'h0);

    wr_reg(8'h04, 32'h0);
    wr_reg(8'h08, 32'h1);
    idle(3);
    gin_cur = 17'h1_0001;
    idle(2);
    chk("irq_before_3rd_edge", 32'(GPIOIRQ), 32'h0);
    idle(1);
    chk("irq_on_3rd_edge", 32'(GPIOIRQ), 32'h1);
    wr_reg(8'h0C, 32'h1);
    chk("irq_cleared", 32'(GPIOIRQ), 32'h0);
    gin_cur = '0;
    idle(4);
    gin_cur = 17'h1_0001;
    idle(1);
    cyc(1'b1, 1'b1, 2'b10, 8'h0C, 32'h0, 1'b0, gin_cur);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 32'h1, 1'b0, gin_cur);
    chk("set_beats_clear", 32'(GPIOIRQ), 32'h1);

    gin_cur = '0;
    idle(4);
    wr_reg(8'h14, 32'h1);
    chk("parerr_clear", 32'(PARITYERR), 32'h0);
    gin_cur = 17'h0_0001;
    idle(3);
    chk("parerr_set", 32'(PARITYERR), 32'h1);
    gin_cur = 17'h1_0001;
    idle(4);
    chk("parerr_sticky", 32'(PARITYERR), 32'h1);
    wr_reg(8'h14, 32'h1);
    chk("parerr_w1c", 32'(PARITYERR), 32'h0);

    cyc(1'b1, 1'b1, 2'b10, 8'h04, 32'h0, 1'b0, gin_cur);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 32'hFFFF, 1'b1, gin_cur);
    chk("reset_drops_write", 32'(GPIODIR), 32'h0);
    wr_reg(8'h04, 32'h0000_00F0);
    wr_reg(8'h20, 32'hFFFF_FFFF);
    rd_reg(8'h20);
    chk("unmapped_read", HRDATA, 32'h0);
    chk("unmapped_no_side", 32'(GPIODIR), 32'h0000_00F0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        rnd = $urandom;
        gin_cur = rnd[W:0];
      end
      tr = ($urandom_range(0, 3) > 0) ? 2'b10 : 2'($urandom_range(0, 3));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tr,
          addr_tab[$urandom_range(0, 7)], $urandom, ($urandom_range(0, 59) == 0), gin_cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
